// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared types and default constants for the front-panel conditioner
package panel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        HOLD   = 2'd2,
        REPEAT = 2'd3
    } adv_state_t;

    localparam int TICK_DIV_DEF = 100;
    localparam int DEB_CYC_DEF  = 4;
    localparam int REP_DLY_DEF  = 3;
    localparam int SYNC_STAGES  = 2;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus consecutive-cycle debounce for one button
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   btn_raw  asynchronous raw button level
//   btn_deb  debounced level; follows btn_raw 2+DEB_CYC cycles after a clean change
module btn_debounce
    import panel_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_deb
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], btn_raw};
        stable_d = stable_q;
        cnt_d    = '0;
        // Any agreeing cycle restarts the count, so only an unbroken run of
        // DEB_CYC mismatching cycles is accepted.
        if (sync_q[SYNC_STAGES-1] != stable_q) begin
            if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
                stable_d = sync_q[SYNC_STAGES-1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign btn_deb = stable_q;

endmodule

// File: rtl/panel_input_ctrl.sv
// rtl/panel_input_ctrl.sv - front-panel conditioner: debounce, Pulse prescaler, mode levels, advance enables
//
// Ports:
//   clk, rst                     system clock, synchronous active-high reset
//   btn_timeset/alarmset/minadv/hrsadv/alarmon   raw asynchronous buttons
//   Pulse                        square wave, period TICK_DIV clk, high for the upper half
//   tick                         one-clk strobe in the last cycle of each Pulse period
//   Timeset, Alarmset, Alarmon   debounced levels, updated only on tick
//   Minadv, Hrsadv               advance enables (single step, then auto-repeat)
//
// Build option ALARMON_TOGGLE_EN: Alarmon becomes a toggle that flips at the
// tick following one or more debounced rising edges of btn_alarmon.
module panel_input_ctrl
    import panel_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int REP_DLY  = REP_DLY_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_timeset,
    input  logic btn_alarmset,
    input  logic btn_minadv,
    input  logic btn_hrsadv,
    input  logic btn_alarmon,
    output logic Pulse,
    output logic tick,
    output logic Timeset,
    output logic Alarmset,
    output logic Alarmon,
    output logic Minadv,
    output logic Hrsadv
);

    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(REP_DLY + 1);

    localparam int B_TS  = 0;
    localparam int B_AS  = 1;
    localparam int B_MIN = 2;
    localparam int B_HRS = 3;
    localparam int B_AON = 4;

    logic [4:0] btn_raw;
    logic [4:0] btn_deb;

    assign btn_raw = {btn_alarmon, btn_hrsadv, btn_minadv, btn_alarmset, btn_timeset};

    for (genvar g = 0; g < 5; g++) begin : g_deb
        btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[g]),
            .btn_deb (btn_deb[g])
        );
    end

    // Prescaler
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pulse_q, pulse_d;
    logic             tick_w;

    assign tick_w = (div_cnt_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        div_cnt_d = tick_w ? '0 : div_cnt_q + 1'b1;
        // Computed from the next count so the registered Pulse lines up with div_cnt_q.
        pulse_d   = (div_cnt_d >= DIV_W'(TICK_DIV / 2));
    end

    // Tick-aligned mode levels
    logic timeset_q, timeset_d;
    logic alarmset_q, alarmset_d;
    logic alarmon_q, alarmon_d;

    always_comb begin
        timeset_d  = tick_w ? btn_deb[B_TS] : timeset_q;
        alarmset_d = tick_w ? btn_deb[B_AS] : alarmset_q;
    end

`ifdef ALARMON_TOGGLE_EN
    logic alarmon_prev_q, alarmon_prev_d;
    logic alarmon_pend_q, alarmon_pend_d;
    logic alarmon_rise;

    // Rising edges are collected until the next tick, where any number of them
    // counts as a single toggle.
    always_comb begin
        alarmon_rise   = btn_deb[B_AON] & ~alarmon_prev_q;
        alarmon_prev_d = btn_deb[B_AON];
        alarmon_pend_d = tick_w ? 1'b0 : (alarmon_pend_q | alarmon_rise);
        alarmon_d      = tick_w ? (alarmon_q ^ (alarmon_pend_q | alarmon_rise)) : alarmon_q;
    end
`else
    always_comb begin
        alarmon_d = tick_w ? btn_deb[B_AON] : alarmon_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q      <= '0;
            pulse_q        <= 1'b0;
            timeset_q      <= 1'b0;
            alarmset_q     <= 1'b0;
            alarmon_q      <= 1'b0;
`ifdef ALARMON_TOGGLE_EN
            alarmon_prev_q <= 1'b0;
            alarmon_pend_q <= 1'b0;
`endif
        end else begin
            div_cnt_q      <= div_cnt_d;
            pulse_q        <= pulse_d;
            timeset_q      <= timeset_d;
            alarmset_q     <= alarmset_d;
            alarmon_q      <= alarmon_d;
`ifdef ALARMON_TOGGLE_EN
            alarmon_prev_q <= alarmon_prev_d;
            alarmon_pend_q <= alarmon_pend_d;
`endif
        end
    end

    // Advance FSMs: index 0 = minutes, 1 = hours. Evaluated only on tick so the
    // registered enables are stable across each Pulse rising edge.
    adv_state_t        adv_st_q  [2];
    logic [HOLD_W-1:0] hold_cnt_q[2];
    logic [1:0]        adv_q;
    logic [1:0]        adv_press;
    logic              adv_ok;

    assign adv_press = {btn_deb[B_HRS], btn_deb[B_MIN]};
    assign adv_ok    = btn_deb[B_TS] ^ btn_deb[B_AS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                adv_st_q[i]   <= IDLE;
                hold_cnt_q[i] <= '0;
            end
            adv_q <= '0;
        end else if (tick_w) begin
            for (int i = 0; i < 2; i++) begin
                if (!adv_ok) begin
                    adv_st_q[i] <= IDLE;
                    adv_q[i]    <= 1'b0;
                end else begin
                    case (adv_st_q[i])
                        IDLE: begin
                            if (adv_press[i]) begin
                                adv_st_q[i] <= STEP;
                                adv_q[i]    <= 1'b1;
                            end
                        end
                        STEP: begin
                            adv_q[i] <= 1'b0;
                            if (adv_press[i]) begin
                                adv_st_q[i]   <= HOLD;
                                hold_cnt_q[i] <= HOLD_W'(1);
                            end else begin
                                adv_st_q[i] <= IDLE;
                            end
                        end
                        HOLD: begin
                            if (!adv_press[i]) begin
                                adv_st_q[i] <= IDLE;
                            end else if (hold_cnt_q[i] == HOLD_W'(REP_DLY)) begin
                                adv_st_q[i] <= REPEAT;
                                adv_q[i]    <= 1'b1;
                            end else begin
                                hold_cnt_q[i] <= hold_cnt_q[i] + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (!adv_press[i]) begin
                                adv_st_q[i] <= IDLE;
                                adv_q[i]    <= 1'b0;
                            end
                        end
                        default: begin
                            adv_st_q[i] <= IDLE;
                            adv_q[i]    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign Pulse    = pulse_q;
    assign tick     = tick_w;
    assign Timeset  = timeset_q;
    assign Alarmset = alarmset_q;
    assign Alarmon  = alarmon_q;
    assign Minadv   = adv_q[0];
    assign Hrsadv   = adv_q[1];

endmodule
